// File: rtl/output_write_scheduler.sv
// output_write_scheduler
//
// Walks an output matrix tile by tile for the output memory writer. A job
// (base address, tile grid, row/column mode) is accepted from the top-level
// controller. One writer instruction is issued per N x N tile in row-major
// tile order. The next instruction is issued only after the writer has
// reported completion of the previous one. Job completion is reported back
// to the controller with its own handshake.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The side driving valid holds valid
// and its payload stable until that transfer.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   job_valid / job_ready      job offer from the controller
//   job_base_address           address of tile (0,0)
//   job_tile_rows/_cols        tile grid size (0 gives an empty job)
//   job_output_by_row          1 = row-wise output, 0 = column-wise
//   job_done_valid / _ready    job completion to the controller
//   instruction_valid / _ready writer instruction channel
//   address_output             tile address for the writer
//   output_by_row_instruction  latched output mode for the writer
//   completed_valid / _ready   writer completion channel
//   busy                       high whenever the FSM is not IDLE
//   tiles_written              tiles completed in the current or last job
//   dbg_state                  raw FSM state, for observation only
module output_write_scheduler #(
    parameter int N                   = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int MAX_TILES           = 16,
    parameter int TILE_COUNT_BITS     = $clog2(MAX_TILES + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0] job_base_address,
    input  logic [TILE_COUNT_BITS-1:0]     job_tile_rows,
    input  logic [TILE_COUNT_BITS-1:0]     job_tile_cols,
    input  logic                           job_output_by_row,
    output logic                           job_done_valid,
    input  logic                           job_done_ready,
    output logic                           instruction_valid,
    input  logic                           instruction_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0] address_output,
    output logic                           output_by_row_instruction,
    input  logic                           completed_valid,
    output logic                           completed_ready,
    output logic                           busy,
    output logic [2*TILE_COUNT_BITS-1:0]   tiles_written,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int TW = 2 * TILE_COUNT_BITS;

    // Distance between consecutive tiles; addresses wrap modulo 2^MEMORY_ADDRESS_BITS.
    localparam logic [MEMORY_ADDRESS_BITS-1:0] TILE_STRIDE = MEMORY_ADDRESS_BITS'(N * N);
    localparam logic [TILE_COUNT_BITS-1:0]     ONE_TILE    = 1;
    localparam logic [TW-1:0]                  ONE_COUNT   = 1;

    state_t                           r_state;
    logic [MEMORY_ADDRESS_BITS-1:0]   r_tile_address;
    logic [TILE_COUNT_BITS-1:0]       r_rows;
    logic [TILE_COUNT_BITS-1:0]       r_cols;
    logic [TILE_COUNT_BITS-1:0]       r_tile_r;
    logic [TILE_COUNT_BITS-1:0]       r_tile_c;
    logic                             r_by_row;
    logic [TW-1:0]                    r_tiles_written;

    logic                             w_last_col;
    logic                             w_last_row;

    // Only evaluated in WAIT_DONE, where rows and cols are known to be nonzero.
    assign w_last_col = (r_tile_c == r_cols - ONE_TILE);
    assign w_last_row = (r_tile_r == r_rows - ONE_TILE);

    // Handshake outputs are decoded from the state register alone, so no
    // input reaches an output combinationally.
    assign job_ready                 = (r_state == IDLE);
    assign instruction_valid         = (r_state == ISSUE);
    assign completed_ready           = (r_state == WAIT_DONE);
    assign job_done_valid            = (r_state == DONE);
    assign busy                      = (r_state != IDLE);
    assign address_output            = r_tile_address;
    assign output_by_row_instruction = r_by_row;
    assign tiles_written             = r_tiles_written;
    assign dbg_state                 = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_tile_address  <= '0;
            r_rows          <= '0;
            r_cols          <= '0;
            r_tile_r        <= '0;
            r_tile_c        <= '0;
            r_by_row        <= 1'b0;
            r_tiles_written <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_tile_address  <= job_base_address;
                        r_rows          <= job_tile_rows;
                        r_cols          <= job_tile_cols;
                        r_by_row        <= job_output_by_row;
                        r_tile_r        <= '0;
                        r_tile_c        <= '0;
                        r_tiles_written <= '0;
                        // An empty grid has nothing to write; report it done at once.
                        if (job_tile_rows == '0 || job_tile_cols == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (instruction_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (completed_valid) begin
                        r_tiles_written <= r_tiles_written + ONE_COUNT;
                        // Row-major order means every tile is one stride past the
                        // previous one, so an accumulator replaces r*cols+c.
                        r_tile_address  <= r_tile_address + TILE_STRIDE;
                        if (w_last_col) begin
                            r_tile_c <= '0;
                            r_tile_r <= r_tile_r + ONE_TILE;
                        end else begin
                            r_tile_c <= r_tile_c + ONE_TILE;
                        end
                        if (w_last_row && w_last_col) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    if (job_done_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/output_write_scheduler.md
# output_write_scheduler

Sequences the output memory writer across a full output matrix. Accepts one job (base address, tile grid size, row/column output mode), issues one writer instruction per N×N output tile in row-major tile order, and waits for the writer's completion handshake before issuing the next. Signals job completion to the top-level controller with its own handshake. Sits between the top-level controller and the output memory writer, driving that writer's instruction and completion ports.

## Interface
- N, 4: processing-array width; one tile is N×N outputs.
- MEMORY_ADDRESS_BITS, 64: address width, matching the writer.
- MAX_TILES, 16: maximum tile rows or tile columns per job.
- TILE_COUNT_BITS, $clog2(MAX_TILES+1): width of the tile-count fields.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered by the controller.
- job_ready  out  1  scheduler can accept a job.
- job_base_address  in  MEMORY_ADDRESS_BITS  address of tile (0,0).
- job_tile_rows  in  TILE_COUNT_BITS  number of tile rows.
- job_tile_cols  in  TILE_COUNT_BITS  number of tile columns.
- job_output_by_row  in  1  1 = row-wise output, 0 = column-wise.
- job_done_valid  out  1  job finished.
- job_done_ready  in  1  controller accepts the completion.
- instruction_valid  out  1  to writer instruction_valid.
- instruction_ready  in  1  from writer instruction_ready.
- address_output  out  MEMORY_ADDRESS_BITS  to writer address_input.
- output_by_row_instruction  out  1  to writer output_by_row_instruction.
- completed_valid  in  1  from writer completed_valid.
- completed_ready  out  1  to writer completed_ready.
- busy  out  1  high in every state except IDLE.
- tiles_written  out  2*TILE_COUNT_BITS  count of tiles completed in the current or last job.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, DONE.
- **IDLE**
  - job_ready=1.
  - On job_valid&&job_ready, latch the job fields, set tile_address=job_base_address, tile_r=0, tile_c=0, tiles_written=0.
  - If job_tile_rows==0 or job_tile_cols==0, go to DONE. Otherwise go to ISSUE.
- **ISSUE**
  - instruction_valid=1; address_output=tile_address; output_by_row_instruction=latched mode.
  - On instruction_valid&&instruction_ready, go to WAIT_DONE.
- **WAIT_DONE**
  - completed_ready=1.
  - On completed_valid&&completed_ready:
    - tiles_written+=1 and tile_address+=N*N.
    - Advance tile_c; on tile_c==cols-1, wrap tile_c to 0 and increment tile_r.
    - If this was the last tile (tile_r==rows-1 and tile_c==cols-1), go to DONE. Otherwise go to ISSUE.
- **DONE**
  - job_done_valid=1.
  - On job_done_ready, go to IDLE. tiles_written holds its value until the next job is accepted.
- Address arithmetic is an accumulator only (no multiplier). It is modulo 2^MEMORY_ADDRESS_BITS and wraps silently.
- Tile (r,c) address = base + (r*cols+c)*N*N.
- At most one writer instruction is outstanding at a time.
- Job fields are sampled only at acceptance. Changes on the job inputs afterwards are ignored.
- completed_valid seen outside WAIT_DONE is not acknowledged (completed_ready=0) and has no effect.
- Job values above MAX_TILES are out of contract; behaviour is unspecified.

## Timing
- Reset (asynchronous) forces state=IDLE and clears all registers. Output values while reset is asserted:
  - job_ready=1 (decoded from IDLE).
  - job_done_valid=0, instruction_valid=0, completed_ready=0, busy=0.
  - address_output=0, output_by_row_instruction=0, tiles_written=0.
- Reset mid-job abandons the job. No further instructions are issued.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Latencies:
  - Job acceptance to first instruction_valid: 1 cycle.
  - Instruction handshake to completed_ready high: 1 cycle.
  - Completion handshake to next instruction_valid: 1 cycle.
  - Last completion to job_done_valid: 1 cycle.
  - Done handshake to job_ready: 1 cycle.
- Handshake signals are held stable while valid is high and ready is low.
- A job offered in the same cycle as a done handshake is not accepted, because job_ready=0 in DONE.

## Test plan
- **Single 1×1 tile job:** job base=0x100, rows=1, cols=1, by_row=1, writer ready immediately.
  - Exactly one instruction with address 0x100 and by_row=1.
  - job_done_valid is high 1 cycle after the completion handshake; tiles_written=1.
- **2×3 grid, N=4, base=0x1000:** instruction addresses must be, in order, 0x1000, 0x1010, 0x1020, 0x1030, 0x1040, 0x1050.
  - Never two instructions without an intervening completion; tiles_written=6.
- **Zero dimension:** rows=0, cols=5 goes IDLE→DONE with no instruction_valid pulse; tiles_written=0.
- **Backpressure:** hold instruction_ready low for 7 cycles and completed_valid delayed 10 cycles.
  - instruction_valid and address stay stable throughout.
  - completed_ready stays high until the handshake.
  - A completed_valid asserted while in ISSUE is not acknowledged.
- **Address wrap:** MEMORY_ADDRESS_BITS=8, base=0xF0, rows=1, cols=2 → addresses 0xF0 then 0x00.
- **Reset mid-job:** assert reset asynchronously (between clock edges) during WAIT_DONE of tile 2 of 4.
  - Outputs take their reset values immediately, before the next edge.
  - After release, a new job runs cleanly from its own base address.
